clk_divider_prog: RTL

CLK_DIVIDER_PROG -- requirements
Module: clk_divider_prog

---
 rtl/clk_div_pkg.sv | 19 +
 rtl/clk_div_chan.sv | 114 +++++++++++
 rtl/clk_divider_prog.sv | 57 +++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared defaults for the programmable clock divider.
//   DEF_W      : default counter / divisor width
//   DEF_DIV    : default reset half-period divisor
//   ch_idx_w() : width of the channel-select bus for a given channel count
//                (never narrower than one bit, so a single-channel build
//                still has a legal load_ch port)
// -----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int          DEF_W   = 32;
    localparam int unsigned DEF_DIV = 50_000_000;

    function automatic int ch_idx_w(input int ch);
        return (ch <= 1) ? 1 : $clog2(ch);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// -----------------------------------------------------------------------------
// clk_div_chan
// One divider channel: half-period counter, active and pending divisor,
// output toggle flop and toggle tick.
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   en_i            : count enable for this channel
//   load_hit_i      : load strobe already decoded for this channel
//   div_i           : divisor value accompanying load_hit_i
//   sync_i          : realign strobe shared by all channels
//   clk_out_o       : divided clock (registered)
//   tick_o          : one-cycle pulse in the cycle clk_out_o toggles
// A new divisor is parked in the pending register and only promoted at a
// half-period boundary so an enabled output never sees a shortened half-period.
// -----------------------------------------------------------------------------
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int          W           = DEF_W,
    parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         load_hit_i,
    input  logic [W-1:0] div_i,
    input  logic         sync_i,
    output logic         clk_out_o,
    output logic         tick_o
);

    logic [W-1:0] cnt_q,  cnt_d;
    logic [W-1:0] n_q,    n_d;
    logic [W-1:0] pend_q, pend_d;
    logic         pv_q,   pv_d;
    logic         clk_q,  clk_d;
    logic         tick_q, tick_d;

    logic [W-1:0] last_cnt;
    logic         wrap;

    // N = 0 behaves as N = 1, so the terminal count is 0 in both cases.
    assign last_cnt = (n_q == '0) ? '0 : (n_q - W'(1));
    assign wrap     = en_i && (cnt_q == last_cnt);

    always_comb begin
        cnt_d  = cnt_q;
        n_d    = n_q;
        pend_d = pend_q;
        pv_d   = pv_q;
        clk_d  = clk_q;
        tick_d = 1'b0;

        if (sync_i) begin
            cnt_d = '0;
            clk_d = 1'b0;
            if (pv_q) begin
                n_d = pend_q;
            end
            pv_d = 1'b0;
            // A load coinciding with sync bypasses the pending register.
            if (load_hit_i) begin
                n_d = div_i;
            end
        end else begin
            if (en_i) begin
                if (wrap) begin
                    cnt_d  = '0;
                    clk_d  = ~clk_q;
                    tick_d = 1'b1;
                    if (pv_q) begin
                        n_d  = pend_q;
                        pv_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end else if (pv_q && (cnt_q == '0)) begin
                // Parked at a boundary with no half-period in progress.
                n_d  = pend_q;
                pv_d = 1'b0;
            end

            // Applied after promotion so a load landing on a wrap cycle is
            // kept for the next boundary rather than lost.
            if (load_hit_i) begin
                pend_d = div_i;
                pv_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            n_q    <= W'(DEFAULT_DIV);
            pend_q <= '0;
            pv_q   <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            n_q    <= n_d;
            pend_q <= pend_d;
            pv_q   <= pv_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clk_out_o = clk_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/clk_divider_prog.sv
// -----------------------------------------------------------------------------
// clk_divider_prog
// CH independent programmable clock dividers sharing one load bus and one
// sync strobe. Output period per channel is 2*N clk cycles (N = 0 acts as 1).
// Ports:
//   clk      : system clock
//   rst      : synchronous active-low reset
//   en       : per-channel count enable
//   load     : one-cycle strobe writing div_in to channel load_ch
//   load_ch  : target channel; indices >= CH match no channel
//   div_in   : new half-period divisor
//   sync     : one-cycle strobe realigning all channels
//   clk_out  : divided clocks
//   tick     : one-cycle pulse on each clk_out toggle
// -----------------------------------------------------------------------------
module clk_divider_prog
    import clk_div_pkg::*;
#(
    parameter int          CH          = 4,
    parameter int          W           = DEF_W,
    parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CH-1:0]             en,
    input  logic                      load,
    input  logic [ch_idx_w(CH)-1:0]   load_ch,
    input  logic [W-1:0]              div_in,
    input  logic                      sync,
    output logic [CH-1:0]             clk_out,
    output logic [CH-1:0]             tick
);

    localparam int LW = ch_idx_w(CH);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        logic load_hit;

        // Out-of-range indices simply never match, so they are dropped.
        assign load_hit = load && (load_ch == LW'(i));

        clk_div_chan #(
            .W           (W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .en_i       (en[i]),
            .load_hit_i (load_hit),
            .div_i      (div_in),
            .sync_i     (sync),
            .clk_out_o  (clk_out[i]),
            .tick_o     (tick[i])
        );
    end

endmodule
